ro_puf_axil_regbank: RTL
========================

Name: ro_puf_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank, the next-generation control/status front end for the ring-oscillator PUF IP.
- Replaces the fixed 4-register scratch slave with a control register, a status register and a captured response register, plus a configurable number of challenge registers driven into the PUF core.
- Supports independent AW/W arrival, byte strobes, a self-clearing start pulse and a W1C sticky done flag.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width and register width (32 only; checked at elaboration).
NUM_REGS, 8, register count; power of 2, >=4.
C_S_AXI_ADDR_WIDTH, clog2(NUM_REGS)+2, byte address width (derived; do not override).

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  always 2'b00
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
puf_start  out  1  one-cycle start pulse
puf_cfg  out  31  CTRL[31:1]
puf_challenge  out  (NUM_REGS-3)*32  regs 3..NUM_REGS-1, reg 3 in LSBs
puf_busy  in  1  core busy level
puf_done  in  1  one-cycle completion pulse
puf_response  in  32  response, valid while puf_done=1

Behaviour:
- Register map (index = addr[ADDR_W-1:2]; addr[1:0] ignored):
  - 0 CTRL: bit0 START reads 0; bits[31:1] RW.
  - 1 STATUS: bit0 = puf_busy (live); bit1 = DONE, sticky, W1C; other bits read 0.
  - 2 RESP: RO; writes ignored but acknowledged.
  - 3..NUM_REGS-1: RW challenge registers.
- Reset (ARESET=1 at edge):
  - All registers 0; DONE=0; aw_held=w_held=0.
  - BVALID=RVALID=0, RDATA=0, puf_start=0.
  - Any outstanding transaction is dropped; no B/R is issued for it after reset.
- Write path:
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - An AW handshake latches the address and sets aw_held. A W handshake latches data and strobes and sets w_held. AW and W may arrive in either order or in the same cycle.
  - Commit edge: first edge with aw_held && w_held && !BVALID. At that edge the register update applies, BVALID is set, and aw_held/w_held clear. Same-cycle AW+W at edge k gives commit at k+1.
  - BVALID holds until BREADY; the next AW/W is accepted from the cycle after B completes.
  - RW registers update per byte where WSTRB[b]=1. CTRL byte 0 strobe gates START.
  - START: a committed CTRL write with WDATA[0]=1 and WSTRB[0]=1 gives puf_start=1 for exactly the cycle after commit. START is never stored.
  - DONE W1C: a committed STATUS write with WDATA[1]=1 and WSTRB[0]=1 clears DONE.
- DONE set: puf_done=1 at an edge sets DONE and captures puf_response into RESP. If a set and a W1C land on the same edge, set wins.
- Read path:
  - ARREADY = !RVALID.
  - On AR handshake at edge k, RDATA is loaded with the register value before any update at edge k, and RVALID=1 from k.
  - RVALID and RDATA hold until RREADY.
- Reads and writes are fully concurrent; there is no ordering between channels.
- puf_cfg and puf_challenge are driven directly from the registers, with no extra latency.

Test Plan:
1. Reset, then write 0x11111111..0x55555555 to regs 3..7 with WSTRB=0xF, then read back -> each read equals the value written; BRESP=RRESP=0; puf_challenge[31:0]=0x11111111.
2. W presented 3 cycles before AW to reg 4, data 0xA5A5A5A5 -> one B only, after AW arrives; reg 4=0xA5A5A5A5. Then WSTRB=0x2 with data 0xFFFFFFFF -> reg 4=0xA5A5FFA5.
3. Write CTRL=0x00000007 -> puf_start high exactly 1 cycle; CTRL reads 0x00000006; puf_cfg=0x3.
4. Pulse puf_done with puf_response=0xDEADBEEF, puf_busy=0 -> STATUS reads 0x2, RESP reads 0xDEADBEEF. Write STATUS=0x2 -> STATUS reads 0x0. Repeat with the W1C commit on the same edge as puf_done -> STATUS reads 0x2.
5. Hold BREADY=0 for 5 cycles after a write -> BVALID stays 1 and AWREADY/WREADY stay 0. Hold RREADY=0 -> RDATA is stable and ARREADY=0.
6. Assert ARESET while BVALID=1 and a held AW is pending -> next cycle BVALID=0, all registers 0, no spurious B after reset is released.

Source files
------------

// File: rtl/ro_puf_axil_regbank.sv
// rtl/ro_puf_axil_regbank.sv - AXI4-Lite control/status register bank for the RO PUF core
// CTRL/STATUS/RESP plus challenge registers; independent AW/W capture, W1C done flag, start pulse.

module ro_puf_axil_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 8,
  parameter int C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS) + 2
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            puf_start,
  output logic [30:0]                     puf_cfg,
  output logic [(NUM_REGS-3)*32-1:0]      puf_challenge,
  input  logic                            puf_busy,
  input  logic                            puf_done,
  input  logic [31:0]                     puf_response
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int NCH   = NUM_REGS - 3;

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
    $error("ro_puf_axil_regbank: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (NUM_REGS < 4 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
    $error("ro_puf_axil_regbank: NUM_REGS must be a power of 2 and >= 4");
  end

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic             aw_held_q, aw_held_d;
  logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic             w_held_q, w_held_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:1]      ctrl_q, ctrl_d;
  logic             done_q, done_d;
  logic [31:0]      resp_q, resp_d;
  logic             start_q, start_d;
  logic [31:0]      chal_q [NCH];
  logic [31:0]      chal_d [NCH];

  logic             aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      rd_val, ctrl_wr;
  logic             unused_bits;

  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign puf_start     = start_q;
  assign puf_cfg       = ctrl_q;

  for (genvar k = 0; k < NCH; k++) begin : g_chal
    assign puf_challenge[k*32 +: 32] = chal_q[k];
  end

  assign aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit  = aw_held_q && w_held_q && !bvalid_q;
  assign rd_idx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign ctrl_wr = byte_merge({ctrl_q, 1'b0}, wdata_q, wstrb_q);

  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], ctrl_wr[0]};

  always_comb begin
    rd_val = '0;
    if (rd_idx == IDX_W'(0))      rd_val = {ctrl_q, 1'b0};
    else if (rd_idx == IDX_W'(1)) rd_val = {30'd0, done_q, puf_busy};
    else if (rd_idx == IDX_W'(2)) rd_val = resp_q;
    else begin
      for (int k = 0; k < NCH; k++) begin
        if (rd_idx == IDX_W'(k + 3)) rd_val = chal_q[k];
      end
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ctrl_d    = ctrl_q;
    done_d    = done_q;
    resp_d    = resp_q;
    chal_d    = chal_q;
    start_d   = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (aw_idx_q == IDX_W'(0)) begin
        ctrl_d  = ctrl_wr[31:1];
        start_d = wstrb_q[0] && wdata_q[0];
      end else if (aw_idx_q == IDX_W'(1)) begin
        if (wstrb_q[0] && wdata_q[1]) done_d = 1'b0;
      end else begin
        for (int k = 0; k < NCH; k++) begin
          if (aw_idx_q == IDX_W'(k + 3)) chal_d[k] = byte_merge(chal_q[k], wdata_q, wstrb_q);
        end
      end
    end else if (bvalid_q && S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Evaluated after the W1C so a completion on the same edge keeps DONE set.
    if (puf_done) begin
      done_d = 1'b1;
      resp_d = puf_response;
    end

    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      done_q    <= 1'b0;
      resp_q    <= '0;
      start_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) chal_q[k] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      resp_q    <= resp_d;
      start_q   <= start_d;
      for (int k = 0; k < NCH; k++) chal_q[k] <= chal_d[k];
    end
  end

endmodule
